// File: rtl/conditioned_shifter.sv
// conditioned_shifter: debounced load/shift/dir/sdata controls driving a WIDTH-bit
// left/right shift register with a switch-selected LED window. Option macro: SHIFT_COUNT_EN.

module cond_debounce #(
  parameter int WAIT_TIME = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o
);
  localparam int CW = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          clean_q, clean_dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      clean_q     <= 1'b0;
      clean_dly_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], raw_i};
      clean_dly_q <= clean_q;
      if (sync_q[1] == clean_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(WAIT_TIME - 1)) begin
        clean_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = clean_q & ~clean_dly_q;
endmodule

module conditioned_shifter #(
  parameter int WIDTH     = 8,
  parameter int LED_WIDTH = 4,
  parameter int SEL_WIDTH = 1,
  parameter int WAIT_TIME = 3,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pLoad,
  input  logic [WIDTH-1:0]     pdataIn,
  input  logic                 shift,
  input  logic                 dir,
  input  logic                 sdataIn,
  input  logic [SEL_WIDTH-1:0] ledSel,
  output logic [WIDTH-1:0]     parallelOut,
  output logic                 serialOut,
  output logic [LED_WIDTH-1:0] leds
`ifdef SHIFT_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] shiftCount,
  output logic                 flushed
`endif
);
  localparam int NWIN = WIDTH / LED_WIDTH;

  if (WIDTH < 2 || (WIDTH % LED_WIDTH) != 0) begin : g_bad_width
    $error("conditioned_shifter: WIDTH must be >= 2 and a multiple of LED_WIDTH");
  end
  if ((2 ** SEL_WIDTH) < NWIN || WAIT_TIME < 1 || (2 ** CNT_WIDTH) <= WIDTH) begin : g_bad_cfg
    $error("conditioned_shifter: SEL_WIDTH, WAIT_TIME or CNT_WIDTH out of range");
  end

  // Conditioner lanes: 0 pLoad, 1 shift, 2 dir, 3 sdataIn
  logic [3:0] raw, clean, rise;
  assign raw = {sdataIn, dir, shift, pLoad};

  for (genvar i = 0; i < 4; i++) begin : g_cond
    cond_debounce #(.WAIT_TIME(WAIT_TIME)) u_cond (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (raw[i]),
      .clean_o (clean[i]),
      .rise_o  (rise[i])
    );
  end

  logic unused_rise;
  assign unused_rise = rise[0] ^ rise[2] ^ rise[3];

  logic do_load, do_shift;
  assign do_load  = clean[0];
  assign do_shift = rise[1] & ~clean[0];

  logic [WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (do_load)
      sh_d = pdataIn;
    else if (do_shift)
      sh_d = clean[2] ? {clean[3], sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], clean[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) sh_q <= '0;
    else       sh_q <= sh_d;
  end

  assign parallelOut = sh_q;
  assign serialOut   = clean[2] ? sh_q[0] : sh_q[WIDTH-1];

  // Window select; a select beyond the last window blanks the LEDs
  logic [NWIN-1:0][LED_WIDTH-1:0] win;
  assign win = sh_q;

  always_comb begin
    leds = '0;
    for (int i = 0; i < NWIN; i++)
      if (int'(ledSel) == i) leds = win[i];
  end

`ifdef SHIFT_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (do_load)
      cnt_d = '0;
    else if (do_shift && cnt_q != CNT_WIDTH'(WIDTH))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign shiftCount = cnt_q;
  assign flushed    = (cnt_q == CNT_WIDTH'(WIDTH));
`endif
endmodule
